sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 26 ++
 rtl/sram_word_cycle.sv | 77 +++++++
 rtl/sram_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM arbiter: arbiter states, word-cycle phases
// and the CPU/DMA grant identity.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    C0A,
    C0B,
    C1A,
    C1B,
    D0A,
    D0B
  } arb_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_A,
    PH_B
  } phase_t;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_DMA = 1'b1
  } grant_t;

endpackage

// File: rtl/sram_word_cycle.sv
// One 16-bit SRAM access: a setup (A) cycle then a strobe (B) cycle.
// All strobes, address and write data are registered.
module sram_word_cycle
  import sram_arb_pkg::*;
#(
  parameter int ASIZE = 18
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             start,
  input  logic             rnw,
  input  logic [ASIZE-1:0] addr,
  input  logic [15:0]      wdata,
  input  logic [15:0]      ram_data_in,
  output logic             ram_cs_b,
  output logic             ram_oe_b,
  output logic             ram_we_b,
  output logic [ASIZE-1:0] ram_addr,
  output logic [15:0]      ram_data_out,
  output logic             ram_data_oe,
  output logic [15:0]      rdata,
  output logic             done
);

  phase_t phase, phase_nxt;
  logic   rnw_q;

  always_comb begin
    phase_nxt = phase;
    if (start) begin
      phase_nxt = PH_A;
    end else begin
      case (phase)
        PH_A:    phase_nxt = PH_B;
        PH_B:    phase_nxt = PH_IDLE;
        default: phase_nxt = PH_IDLE;
      endcase
    end
  end

  // A start issued during B chains straight into the next A, keeping cs_b low.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      phase        <= PH_IDLE;
      rnw_q        <= 1'b1;
      ram_cs_b     <= 1'b1;
      ram_oe_b     <= 1'b1;
      ram_we_b     <= 1'b1;
      ram_data_oe  <= 1'b0;
      ram_addr     <= '0;
      ram_data_out <= '0;
    end else begin
      phase <= phase_nxt;
      if (start) begin
        rnw_q        <= rnw;
        ram_cs_b     <= 1'b0;
        ram_oe_b     <= ~rnw;
        ram_we_b     <= 1'b1;
        ram_data_oe  <= ~rnw;
        ram_addr     <= addr;
        ram_data_out <= wdata;
      end else if (phase == PH_A) begin
        ram_we_b <= rnw_q;
      end else if (phase == PH_B) begin
        ram_cs_b    <= 1'b1;
        ram_oe_b    <= 1'b1;
        ram_we_b    <= 1'b1;
        ram_data_oe <= 1'b0;
      end
    end
  end

  // The owner captures rdata on the edge that ends B.
  assign done  = (phase == PH_B);
  assign rdata = ram_data_in;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for a 16-bit asynchronous SRAM: a 32-bit CPU port (two
// word cycles) and a read-only 16-bit DMA port, alternating on contention.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int CPU_ASIZE = 17,
  parameter int RAM_ASIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset_b,
  input  logic                 cpu_req,
  input  logic                 cpu_rnw,
  input  logic [CPU_ASIZE-1:0] cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ack,
  input  logic                 dma_req,
  input  logic [RAM_ASIZE-1:0] dma_addr,
  output logic [15:0]          dma_rdata,
  output logic                 dma_ack,
  output logic                 ram_cs_b,
  output logic                 ram_oe_b,
  output logic                 ram_we_b,
  output logic [RAM_ASIZE-1:0] ram_addr,
  output logic [15:0]          ram_data_out,
  output logic                 ram_data_oe,
  input  logic [15:0]          ram_data_in
);

  arb_state_t state, state_nxt;
  grant_t     last_grant;

  logic [CPU_ASIZE-1:0] cpu_addr_q;
  logic [15:0]          cpu_wdata_hi_q;
  logic                 cpu_rnw_q;
  logic [15:0]          lo_q;

  logic                 cpu_elig, dma_elig;
  logic                 grant_cpu, grant_dma;
  logic                 wc_start, wc_rnw, wc_done;
  logic [RAM_ASIZE-1:0] wc_addr;
  logic [15:0]          wc_wdata, wc_rdata;

  // A port whose ack is high this cycle sits out one arbitration round.
  assign cpu_elig = cpu_req && !cpu_ack;
  assign dma_elig = dma_req && !dma_ack;

  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    wc_start  = 1'b0;
    wc_rnw    = 1'b1;
    wc_addr   = '0;
    wc_wdata  = '0;
    case (state)
      IDLE: begin
        if (cpu_elig && (!dma_elig || last_grant == GRANT_DMA)) begin
          grant_cpu = 1'b1;
          wc_start  = 1'b1;
          wc_rnw    = cpu_rnw;
          wc_addr   = {cpu_addr, 1'b0};
          wc_wdata  = cpu_wdata[15:0];
          state_nxt = C0A;
        end else if (dma_elig) begin
          grant_dma = 1'b1;
          wc_start  = 1'b1;
          wc_addr   = dma_addr;
          state_nxt = D0A;
        end
      end
      C0A: state_nxt = C0B;
      C0B: begin
        if (wc_done) begin
          wc_start  = 1'b1;
          wc_rnw    = cpu_rnw_q;
          wc_addr   = {cpu_addr_q, 1'b1};
          wc_wdata  = cpu_wdata_hi_q;
          state_nxt = C1A;
        end
      end
      C1A: state_nxt = C1B;
      C1B: if (wc_done) state_nxt = IDLE;
      D0A: state_nxt = D0B;
      D0B: if (wc_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state          <= IDLE;
      last_grant     <= GRANT_CPU;
      cpu_addr_q     <= '0;
      cpu_wdata_hi_q <= '0;
      cpu_rnw_q      <= 1'b1;
      lo_q           <= '0;
      cpu_rdata      <= '0;
      dma_rdata      <= '0;
      cpu_ack        <= 1'b0;
      dma_ack        <= 1'b0;
    end else begin
      state   <= state_nxt;
      cpu_ack <= (state == C1B) && wc_done;
      dma_ack <= (state == D0B) && wc_done;
      if (grant_cpu) begin
        last_grant     <= GRANT_CPU;
        cpu_addr_q     <= cpu_addr;
        cpu_wdata_hi_q <= cpu_wdata[31:16];
        cpu_rnw_q      <= cpu_rnw;
      end
      if (grant_dma) last_grant <= GRANT_DMA;
      if (state == C0B && wc_done && cpu_rnw_q) lo_q <= wc_rdata;
      if (state == C1B && wc_done && cpu_rnw_q) cpu_rdata <= {wc_rdata, lo_q};
      if (state == D0B && wc_done) dma_rdata <= wc_rdata;
    end
  end

  sram_word_cycle #(
    .ASIZE(RAM_ASIZE)
  ) u_word_cycle (
    .clock        (clock),
    .reset_b      (reset_b),
    .start        (wc_start),
    .rnw          (wc_rnw),
    .addr         (wc_addr),
    .wdata        (wc_wdata),
    .ram_data_in  (ram_data_in),
    .ram_cs_b     (ram_cs_b),
    .ram_oe_b     (ram_oe_b),
    .ram_we_b     (ram_we_b),
    .ram_addr     (ram_addr),
    .ram_data_out (ram_data_out),
    .ram_data_oe  (ram_data_oe),
    .rdata        (wc_rdata),
    .done         (wc_done)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, directed vector table, multi-cycle
// corner sequences and a randomized run against a word-level memory model.
module tb_sram_arbiter;

  localparam int CA = 17;
  localparam int RA = 18;

  logic          clock = 1'b0;
  logic          reset_b = 1'b0;
  logic          cpu_req = 1'b0, cpu_rnw = 1'b1;
  logic [CA-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ack;
  logic          dma_req = 1'b0;
  logic [RA-1:0] dma_addr = '0;
  logic [15:0]   dma_rdata;
  logic          dma_ack;
  logic          ram_cs_b, ram_oe_b, ram_we_b, ram_data_oe;
  logic [RA-1:0] ram_addr;
  logic [15:0]   ram_data_out;
  logic [15:0]   ram_data_in = '0;

  always #5 clock = ~clock;

  sram_arbiter #(.CPU_ASIZE(CA), .RAM_ASIZE(RA)) dut (
    .clock(clock), .reset_b(reset_b),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rdata(dma_rdata),
    .dma_ack(dma_ack),
    .ram_cs_b(ram_cs_b), .ram_oe_b(ram_oe_b), .ram_we_b(ram_we_b),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out),
    .ram_data_oe(ram_data_oe), .ram_data_in(ram_data_in)
  );

  // Physical SRAM (written by the DUT) and the reference word memory.
  logic [15:0] mem     [int unsigned];
  logic [15:0] ref_mem [int unsigned];

  function automatic logic [15:0] dflt(int unsigned a);
    return a[15:0] ^ 16'hA5A5;
  endfunction
  function automatic logic [15:0] mem_rd(int unsigned a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction
  function automatic logic [15:0] ref_rd(int unsigned a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  always @(negedge clock)
    ram_data_in = (!ram_cs_b && !ram_oe_b) ? mem_rd(int'(ram_addr)) : 16'h0000;

  typedef struct { int unsigned a; logic [15:0] d; } wr_t;
  wr_t wr_log[$];
  int  oe_we_overlap = 0;

  always @(posedge clock)
    if (reset_b && !ram_cs_b && !ram_we_b) begin
      mem[int'(ram_addr)] = ram_data_out;
      wr_log.push_back('{a: int'(ram_addr), d: ram_data_out});
      if (!ram_oe_b || !ram_data_oe) oe_we_overlap++;
    end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    cpu_req = 1'b0;
    dma_req = 1'b0;
    reset_b = 1'b0;
    tick();
    tick();
    reset_b = 1'b1;
    tick();
  endtask

  task automatic do_cpu(input bit rnw, input int unsigned a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    cpu_rnw = rnw; cpu_addr = a[CA-1:0]; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!cpu_ack && lat < 50);
    rd = cpu_rdata;
    if (cpu_ack && !rnw) begin
      ref_mem[2*a]   = wd[15:0];
      ref_mem[2*a+1] = wd[31:16];
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic do_dma(input int unsigned a, output logic [15:0] rd, output int lat);
    dma_addr = a[RA-1:0]; dma_req = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!dma_ack && lat < 50);
    rd = dma_rdata;
    dma_req = 1'b0;
    tick();
  endtask

  typedef struct {
    bit          dma;
    bit          rnw;
    int unsigned addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tbl[8];
    logic [31:0] rd32;
    logic [15:0] rd16;
    int          lat, t, n, dma_t, cpu_t, acks;
    bit          got[8];

    mem[32'h20] = 16'h5678; mem[32'h21] = 16'h1234;
    ref_mem[32'h20] = 16'h5678; ref_mem[32'h21] = 16'h1234;

    tbl[0] = '{dma:0, rnw:1, addr:32'h00010, wdata:32'h0,        exp_rd:32'h12345678, exp_lat:5};
    tbl[1] = '{dma:0, rnw:0, addr:32'h1FFFF, wdata:32'hDEADBEEF, exp_rd:32'h12345678, exp_lat:5};
    tbl[2] = '{dma:1, rnw:1, addr:32'h3FFFE, wdata:32'h0,        exp_rd:32'h0000BEEF, exp_lat:3};
    tbl[3] = '{dma:1, rnw:1, addr:32'h3FFFF, wdata:32'h0,        exp_rd:32'h0000DEAD, exp_lat:3};
    tbl[4] = '{dma:0, rnw:1, addr:32'h1FFFF, wdata:32'h0,        exp_rd:32'hDEADBEEF, exp_lat:5};
    tbl[5] = '{dma:1, rnw:1, addr:32'h00100, wdata:32'h0,        exp_rd:32'h0000A4A5, exp_lat:3};
    tbl[6] = '{dma:0, rnw:1, addr:32'h00005, wdata:32'h0,        exp_rd:32'hA5AEA5AF, exp_lat:5};
    tbl[7] = '{dma:1, rnw:1, addr:32'h00020, wdata:32'h0,        exp_rd:32'h00005678, exp_lat:3};

    // Reset state
    tick();
    tick();
    check("rst_cs_b", {31'd0, ram_cs_b}, 32'd1);
    check("rst_oe_b", {31'd0, ram_oe_b}, 32'd1);
    check("rst_we_b", {31'd0, ram_we_b}, 32'd1);
    check("rst_data_oe", {31'd0, ram_data_oe}, 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_data_out", {16'd0, ram_data_out}, 32'd0);
    check("rst_acks", {30'd0, cpu_ack, dma_ack}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_rdata", {16'd0, dma_rdata}, 32'd0);
    reset_b = 1'b1;
    tick();

    // Directed vector table
    wr_log.delete();
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].dma) begin
        do_dma(tbl[i].addr, rd16, lat);
        rd32 = {16'd0, rd16};
      end else begin
        do_cpu(tbl[i].rnw, tbl[i].addr, tbl[i].wdata, rd32, lat);
      end
      check($sformatf("vec%0d_data", i), rd32, tbl[i].exp_rd);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
    end
    check("wr_pulse_count", wr_log.size(), 2);
    check("wr0_addr", wr_log.size() > 0 ? wr_log[0].a : 32'hFFFFFFFF, 32'h3FFFE);
    check("wr0_data", wr_log.size() > 0 ? {16'd0, wr_log[0].d} : 32'hFFFFFFFF, 32'hBEEF);
    check("wr1_addr", wr_log.size() > 1 ? wr_log[1].a : 32'hFFFFFFFF, 32'h3FFFF);
    check("wr1_data", wr_log.size() > 1 ? {16'd0, wr_log[1].d} : 32'hFFFFFFFF, 32'hDEAD);
    check("wr_oe_overlap", oe_we_overlap, 0);

    // Reset in C0B of a write
    cpu_rnw = 1'b0; cpu_addr = 17'h00040; cpu_wdata = 32'hCAFEF00D; cpu_req = 1'b1;
    tick();
    check("c0a_strobes", {28'd0, ram_cs_b, ram_oe_b, ram_we_b, ram_data_oe}, 32'b0111);
    check("c0a_addr", 32'(ram_addr), 32'h80);
    check("c0a_wdata", {16'd0, ram_data_out}, 32'hF00D);
    tick();
    check("c0b_we_low", {31'd0, ram_we_b}, 32'd0);
    reset_b = 1'b0;
    #1;
    check("midrst_we_b", {31'd0, ram_we_b}, 32'd1);
    check("midrst_cs_b", {31'd0, ram_cs_b}, 32'd1);
    check("midrst_data_oe", {31'd0, ram_data_oe}, 32'd0);
    cpu_req = 1'b0;
    tick();
    reset_b = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    check("midrst_no_ack", acks, 0);
    check("midrst_no_write", {16'd0, mem_rd(32'h80)}, 32'hA525);
    do_cpu(1'b1, 32'h10, 32'h0, rd32, lat);
    check("post_rst_read", rd32, 32'h12345678);
    check("post_rst_lat", lat, 5);

    // Simultaneous requests just after reset: DMA first
    apply_reset();
    cpu_rnw = 1'b1; cpu_addr = 17'h00010; dma_addr = 18'h00100;
    cpu_req = 1'b1; dma_req = 1'b1;
    dma_t = 0; cpu_t = 0;
    for (int i = 1; i <= 30 && cpu_t == 0; i++) begin
      tick();
      if (dma_ack) begin
        dma_t = i; dma_req = 1'b0;
        check("simul_dma_data", {16'd0, dma_rdata}, 32'hA4A5);
      end
      if (cpu_ack) begin
        cpu_t = i; cpu_req = 1'b0;
        check("simul_cpu_data", cpu_rdata, 32'h12345678);
      end
    end
    check("simul_dma_lat", dma_t, 3);
    check("simul_cpu_lat", cpu_t, 8);
    tick();

    // Request held through its own ack cycle
    cpu_rnw = 1'b1; cpu_addr = 17'h00010; cpu_req = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!cpu_ack && t < 50);
    check("hold_first_lat", t, 5);
    tick();
    check("hold_no_dup", {31'd0, ram_cs_b}, 32'd1);
    t = 1;
    while (!cpu_ack && t < 50) begin tick(); t++; end
    check("hold_second_lat", t, 6);
    cpu_req = 1'b0;
    tick();

    // Both requests held: strict alternation starting with DMA
    apply_reset();
    cpu_addr = 17'h00010; dma_addr = 18'h00020; cpu_rnw = 1'b1;
    cpu_req = 1'b1; dma_req = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      tick();
      if (cpu_ack) begin got[n] = 1'b0; n++; end
      else if (dma_ack) begin got[n] = 1'b1; n++; end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    check("alt_count", n, 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("alt_grant%0d", i), {31'd0, got[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
    tick();
    tick();

    // Randomized traffic against the word-level reference
    begin
      bit          c_act = 0, d_act = 0, c_rnw = 1;
      int unsigned c_a = 0, d_a = 0;
      logic [31:0] c_wd = '0;
      int          c_wait = 0, d_wait = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (!c_act && $urandom_range(0, 2) == 0) begin
          c_rnw = 1'($urandom_range(0, 1));
          c_a   = $urandom_range(0, 15) + ($urandom_range(0, 1) != 0 ? 32'h1FFF0 : 32'h0);
          c_wd  = $urandom;
          cpu_rnw = c_rnw; cpu_addr = c_a[CA-1:0]; cpu_wdata = c_wd; cpu_req = 1'b1;
          c_act = 1; c_wait = 0;
        end
        if (!d_act && $urandom_range(0, 2) == 0) begin
          d_a = $urandom_range(0, 31) + ($urandom_range(0, 1) != 0 ? 32'h3FFE0 : 32'h0);
          dma_addr = d_a[RA-1:0]; dma_req = 1'b1;
          d_act = 1; d_wait = 0;
        end
        tick();
        if (cpu_ack) begin
          if (!c_act) check("rnd_cpu_spurious_ack", 32'd1, 32'd0);
          else if (c_rnw)
            check("rnd_cpu_read", cpu_rdata, {ref_rd(2*c_a+1), ref_rd(2*c_a)});
          else begin
            ref_mem[2*c_a] = c_wd[15:0];
            ref_mem[2*c_a+1] = c_wd[31:16];
            check("rnd_cpu_write", {mem_rd(2*c_a+1), mem_rd(2*c_a)}, c_wd);
          end
          cpu_req = 1'b0; c_act = 0;
        end else if (c_act && ++c_wait > 40) begin
          check("rnd_cpu_timeout", c_wait, 40);
          cpu_req = 1'b0; c_act = 0;
        end
        if (dma_ack) begin
          if (!d_act) check("rnd_dma_spurious_ack", 32'd1, 32'd0);
          else check("rnd_dma_read", {16'd0, dma_rdata}, {16'd0, ref_rd(d_a)});
          dma_req = 1'b0; d_act = 0;
        end else if (d_act && ++d_wait > 40) begin
          check("rnd_dma_timeout", d_wait, 40);
          dma_req = 1'b0; d_act = 0;
        end
      end
    end
    check("rnd_oe_overlap", oe_we_overlap, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
